// File: rtl/bs_in_pkg.sv
// Shared definitions for the zlib bitstream reader: widths, field-length
// decode and the stream bit order agreed with the write-side packer.
package bs_in_pkg;

    localparam int DATA_WD = 32;
    localparam int NUMB_WD = 5;
    localparam int BUF_WD  = 2 * DATA_WD;
    localparam int CNT_WD  = 7;
    localparam int LEN_WD  = NUMB_WD + 1;

    // The packer emits bit 31 of each word first; a reader on the other
    // convention would have to reverse words before staging them.
    localparam bit STREAM_MSB_FIRST = 1'b1;

    // The operation that consumes buffered bits in a given cycle.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FIELD = 2'd1,
        OP_ALIGN = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    // Field length is the length code plus one, widened so that 31 -> 32.
    function automatic logic [LEN_WD-1:0] field_len(input logic [NUMB_WD-1:0] numb);
        return {1'b0, numb} + LEN_WD'(1);
    endfunction

endpackage

// File: rtl/bs_in_extract.sv
// Combinational field extractor: takes the len leading bits of an
// MSB-aligned staging buffer and returns them right-aligned.
module bs_in_extract
    import bs_in_pkg::*;
(
    input  logic [BUF_WD-1:0]  stage,
    input  logic [LEN_WD-1:0]  len,
    output logic [DATA_WD-1:0] field
);

    logic [CNT_WD-1:0] shamt;

    // len is 1..32, so the shift is 32..63 and the result fits in DATA_WD.
    always_comb begin
        shamt = CNT_WD'(BUF_WD) - CNT_WD'(len);
        field = DATA_WD'(stage >> shamt);
    end

endmodule

// File: rtl/bs_in.sv
// Bitstream reader: stages 32-bit words in a 64-bit MSB-aligned buffer and
// serves right-aligned fields of 1..32 bits plus byte-alignment skips.
module bs_in
    import bs_in_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               wval_i,
    input  logic [DATA_WD-1:0] wdat_i,
    output logic               wrdy_o,
    input  logic               req_i,
    input  logic [NUMB_WD-1:0] numb_i,
    input  logic               algn_i,
    input  logic               clr_i,
    output logic               rrdy_o,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic [CNT_WD-1:0]  cnt_o
);

    logic [BUF_WD-1:0]  stage_q, stage_d;
    logic [CNT_WD-1:0]  fill_q, fill_d;
    logic               val_q, val_d;
    logic [DATA_WD-1:0] dat_q, dat_d;

    logic [LEN_WD-1:0]  len;
    logic [DATA_WD-1:0] field;
    logic [DATA_WD-1:0] word;
    logic [CNT_WD-1:0]  take;
    logic [CNT_WD-1:0]  rem;
    logic               load;
    op_e                op;

    assign len  = field_len(numb_i);
    assign word = STREAM_MSB_FIRST ? wdat_i : {<<{wdat_i}};

    // Handshakes: a word moves when wval_i && wrdy_o, a field when
    // req_i && rrdy_o. rrdy_o depends combinationally on numb_i, and the
    // requester holds req_i/numb_i until it is served.
    assign rrdy_o = fill_q >= CNT_WD'(len);
    assign wrdy_o = fill_q <= CNT_WD'(DATA_WD);

    bs_in_extract u_extract (
        .stage (stage_q),
        .len   (len),
        .field (field)
    );

    // A request outranks an align in the same cycle; clear outranks both.
    always_comb begin
        op = OP_NONE;
        if (clr_i) begin
            op = OP_CLEAR;
        end else if (req_i && rrdy_o) begin
            op = OP_FIELD;
        end else if (algn_i && !req_i) begin
            op = OP_ALIGN;
        end
    end

    // Only whole words are loaded, so fill[2:0] is exactly the distance
    // past the last byte boundary.
    always_comb begin
        take = '0;
        case (op)
            OP_FIELD: take = CNT_WD'(len);
            OP_ALIGN: take = CNT_WD'(fill_q[2:0]);
            default:  take = '0;
        endcase
    end

    assign load = wval_i && wrdy_o && (op != OP_CLEAR);
    assign rem  = fill_q - take;

    always_comb begin
        stage_d = stage_q << take;
        fill_d  = rem;
        val_d   = (op == OP_FIELD);
        dat_d   = (op == OP_FIELD) ? field : dat_q;
        if (op == OP_CLEAR) begin
            stage_d = '0;
            fill_d  = '0;
        end else if (load) begin
            // rem <= 32 whenever a load is allowed, so the new word never
            // collides with bits still held in the buffer.
            stage_d = stage_d | ({word, DATA_WD'(0)} >> rem);
            fill_d  = rem + CNT_WD'(DATA_WD);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q <= '0;
            fill_q  <= '0;
            val_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            val_q   <= val_d;
            dat_q   <= dat_d;
        end
    end

    assign val_o = val_q;
    assign dat_o = dat_q;
    assign cnt_o = fill_q;

endmodule
